// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parameterised single-clock show-ahead FIFO
//
// Purpose: DEPTH x WIDTH register FIFO with a registered occupancy counter,
//          combinational status decodes and sticky overflow/underflow flags.
// Ports:
//   i_clk     sole clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_flush   synchronous clear of pointers, count and sticky flags
//   i_push    write strobe, i_wdata sampled when set
//   i_wdata   write data
//   i_pop     read strobe
//   o_rdata   head entry (show-ahead), don't-care while o_empty
//   o_empty   count == 0
//   o_full    count == DEPTH
//   o_afull   count >= AFULL_THR
//   o_count   occupancy 0..DEPTH
//   o_ovf     sticky: push while full without a simultaneous pop
//   o_udf     sticky: pop while empty
module param_sync_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int AFULL_THR = 3,
   parameter int CW        = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_afull,
   output logic [CW-1:0]    o_count,
   output logic             o_ovf,
   output logic             o_udf
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [CW-1:0]    count;
   logic             push_ok;
   logic             pop_ok;

   assign o_count = count;
   assign o_empty = (count == '0);
   assign o_full  = (count == CW'(DEPTH));
   assign o_afull = (count >= CW'(AFULL_THR));
   assign o_rdata = mem[rp];

   // A push into a full FIFO is still accepted when a pop frees the head
   // slot in the same cycle; a pop from an empty FIFO never is, even if a
   // push arrives alongside it.
   assign push_ok = i_push && (!o_full || i_pop);
   assign pop_ok  = i_pop && !o_empty;

   // Storage carries no reset so that neither reset nor flush touches it.
   always_ff @(posedge i_clk) begin
      if (push_ok && !i_flush) begin
         mem[wp] <= i_wdata;
      end
   end

   // Pointers are exactly log2(DEPTH) bits, so DEPTH-1 -> 0 wrap is free.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         o_ovf <= 1'b0;
         o_udf <= 1'b0;
      end else if (i_flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         o_ovf <= 1'b0;
         o_udf <= 1'b0;
      end else begin
         if (push_ok) begin
            wp <= wp + AW'(1);
         end
         if (pop_ok) begin
            rp <= rp + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (i_push && o_full && !i_pop) begin
            o_ovf <= 1'b1;
         end
         if (i_pop && o_empty) begin
            o_udf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - randomized and directed bench for param_sync_fifo
module tb_param_sync_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int THR   = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             push = 1'b0;
   logic [WIDTH-1:0] wdata = '0;
   logic             pop = 1'b0;
   logic [WIDTH-1:0] rdata;
   logic             empty;
   logic             full;
   logic             afull;
   logic [CW-1:0]    count;
   logic             ovf;
   logic             udf;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] q[$];
   logic             m_ovf = 1'b0;
   logic             m_udf = 1'b0;

   param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THR(THR)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_flush (flush),
      .i_push  (push),
      .i_wdata (wdata),
      .i_pop   (pop),
      .o_rdata (rdata),
      .o_empty (empty),
      .o_full  (full),
      .o_afull (afull),
      .o_count (count),
      .o_ovf   (ovf),
      .o_udf   (udf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: a plain queue. Pop is applied before push so a
   // full FIFO with both strobes keeps its size, and an empty one rejects
   // the pop because emptiness is judged before the push lands.
   task automatic model_edge();
      bit was_full;
      bit was_empty;
      if (flush) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         if (pop && was_empty) m_udf = 1'b1;
         if (push && was_full && !pop) m_ovf = 1'b1;
         if (pop && !was_empty) void'(q.pop_front());
         if (push && (!was_full || pop)) q.push_back(wdata);
      end
   endtask

   task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic po, input logic f);
      push  = p;
      wdata = d;
      pop   = po;
      flush = f;
      @(posedge clk);
      model_edge();
      #1;
      push  = 1'b0;
      pop   = 1'b0;
      flush = 1'b0;
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      #1;
      check("rst_async_count", 32'(count), 0);
      check("rst_async_empty", 32'(empty), 1);
      check("rst_async_full",  32'(full),  0);
      check("rst_async_afull", 32'(afull), 0);
      check("rst_async_ovf",   32'(ovf),   0);
      check("rst_async_udf",   32'(udf),   0);
      #3;
      rst_n = 1'b1;
   endtask

   // Per-cycle comparison against the queue model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc_count", 32'(count), 32'(q.size()));
         check("cyc_empty", 32'(empty), 32'(q.size() == 0));
         check("cyc_full",  32'(full),  32'(q.size() == DEPTH));
         check("cyc_afull", 32'(afull), 32'(q.size() >= THR));
         check("cyc_ovf",   32'(ovf),   32'(m_ovf));
         check("cyc_udf",   32'(udf),   32'(m_udf));
         if (q.size() > 0) check("cyc_rdata", 32'(rdata), 32'(q[0]));
      end
   end

   task automatic fill4();
      for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(8'h11 * (i + 1)), 1'b0, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_empty", 32'(empty), 1);
      check("reset_count", 32'(count), 0);
      check("reset_flags", 32'({ovf, udf, full, afull}), 0);
      rst_n = 1'b1;

      // Fill and drain
      for (int i = 0; i < 4; i++) begin
         step(1'b1, WIDTH'(8'h11 * (i + 1)), 1'b0, 1'b0);
         check("fill_count", 32'(count), 32'(i + 1));
         check("fill_afull", 32'(afull), 32'(i >= 2));
         check("fill_full",  32'(full),  32'(i == 3));
      end
      for (int i = 0; i < 4; i++) begin
         check("drain_rdata", 32'(rdata), 32'(8'h11 * (i + 1)));
         step(1'b0, '0, 1'b1, 1'b0);
      end
      check("drain_empty", 32'(empty), 1);

      // Overflow
      fill4();
      step(1'b1, 8'h55, 1'b0, 1'b0);
      check("ovf_set",   32'(ovf),   1);
      check("ovf_count", 32'(count), 4);
      check("ovf_head",  32'(rdata), 32'h11);
      step(1'b0, '0, 1'b1, 1'b0);
      check("ovf_sticky", 32'(ovf), 1);
      step(1'b0, '0, 1'b0, 1'b1);
      check("ovf_flush", 32'(ovf), 0);

      // Full simultaneous push+pop
      fill4();
      step(1'b1, 8'hAA, 1'b1, 1'b0);
      check("fullsim_count", 32'(count), 4);
      check("fullsim_ovf",   32'(ovf),   0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      check("fullsim_last", 32'(rdata), 32'hAA);
      step(1'b0, '0, 1'b1, 1'b0);

      // Empty simultaneous push+pop
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      check("emptysim_count", 32'(count), 1);
      check("emptysim_udf",   32'(udf),   1);
      check("emptysim_rdata", 32'(rdata), 32'h5A);
      step(1'b0, '0, 1'b0, 1'b1);

      // Pointer wrap with interleaved pairs
      for (int i = 0; i < 10; i++) begin
         step(1'b1, WIDTH'(8'hC0 + i), 1'b0, 1'b0);
         check("wrap_count1", 32'(count), 1);
         check("wrap_rdata",  32'(rdata), 32'(8'hC0 + i));
         step(1'b0, '0, 1'b1, 1'b0);
         check("wrap_count0", 32'(count), 0);
      end

      // Flush with push, then async reset, both from count 3 with flags set
      for (int r = 0; r < 2; r++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         fill4();
         step(1'b1, 8'h66, 1'b0, 1'b0);
         step(1'b0, '0, 1'b1, 1'b0);
         check("pre_count", 32'(count), 3);
         check("pre_flags", 32'({ovf, udf}), 32'b11);
         if (r == 0) begin
            step(1'b1, 8'h77, 1'b0, 1'b1);
            check("flush_count", 32'(count), 0);
            check("flush_flags", 32'({ovf, udf}), 0);
            check("flush_empty", 32'(empty), 1);
         end else begin
            async_reset();
         end
      end

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 63) == 0));
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
